// File: rtl/write_back_if.sv
// Write-back stage bus: operands latched from mem_access, data-memory read return,
// and the register-file write/bypass and stall outputs.
interface write_back_if;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] y;
    logic        op_ld_or_ldr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        stall_wb;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        ld_timeout;

    modport master (
        output pc, ir, y, op_ld_or_ldr, mem_rdata, mem_rvalid,
        input  stall_wb, rf_we, rf_wa, rf_wd, ld_timeout
    );

    modport slave (
        input  pc, ir, y, op_ld_or_ldr, mem_rdata, mem_rvalid,
        output stall_wb, rf_we, rf_wa, rf_wd, ld_timeout
    );
endinterface

// File: rtl/write_back.sv
// Beta pipeline WB stage: decodes the latched instruction, drives the register-file
// write port / bypass, and stalls the pipe while a load waits for read data.
module write_back #(
    parameter int unsigned LD_TIMEOUT   = 16,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         rst_n,
    write_back_if.slave  wb
);
    localparam logic [31:0] INST_NOP = 32'h83FF_F800;
    localparam int unsigned CW       = (LD_TIMEOUT < 2) ? 1 : $clog2(LD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TO  = CW'(LD_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_LDR = 6'h1F;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d, ir_q, ir_d, y_q, y_d;
    logic           ld_q, ld_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ld_timeout_q, ld_timeout_d;

    logic [5:0]     opcode;
    logic [4:0]     rc;
    logic           stall, wr;
    logic [31:0]    wd;

    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        y_d          = y_q;
        ld_d         = ld_q;
        state_d      = state_q;
        count_d      = count_q;
        ld_timeout_d = ld_timeout_q;
        stall        = 1'b0;
        wr           = 1'b0;
        wd           = '0;
        opcode       = ir_q[31:26];
        rc           = ir_q[25:21];

        // ld_q gates the wait; an LD/LDR opcode without ld_q has no data source and never writes.
        if (ld_q && (opcode == OP_LD || opcode == OP_LDR)) begin
            if (wb.mem_rvalid) begin
                wr      = 1'b1;
                wd      = wb.mem_rdata;
                state_d = IDLE;
                count_d = '0;
            end else if (state_q == WAIT && LD_TIMEOUT != 0 && count_q == CNT_TO) begin
                wr           = 1'b1;
                wd           = TIMEOUT_DATA;
                ld_timeout_d = 1'b1;
                state_d      = IDLE;
                count_d      = '0;
            end else begin
                stall   = 1'b1;
                state_d = WAIT;
                if (state_q == IDLE)
                    count_d = CW'(1);
                else if (count_q != CNT_MAX)
                    count_d = count_q + CW'(1);
            end
        end else begin
            state_d = IDLE;
            count_d = '0;
            if (opcode == OP_JMP || opcode == OP_BEQ || opcode == OP_BNE) begin
                wr = 1'b1;
                wd = pc_q;
            end else if (opcode[5]) begin
                wr = 1'b1;
                wd = y_q;
            end
        end

        if (!stall) begin
            pc_d = wb.pc;
            ir_d = wb.ir;
            y_d  = wb.y;
            ld_d = wb.op_ld_or_ldr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            ir_q         <= INST_NOP;
            y_q          <= '0;
            ld_q         <= 1'b0;
            count_q      <= '0;
            ld_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            y_q          <= y_d;
            ld_q         <= ld_d;
            count_q      <= count_d;
            ld_timeout_q <= ld_timeout_d;
        end
    end

    assign wb.stall_wb   = stall;
    assign wb.rf_we      = wr && (rc != 5'd31);
    assign wb.rf_wa      = rc;
    assign wb.rf_wd      = wd;
    assign wb.ld_timeout = ld_timeout_q;
endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: a cycle-level model of the WB rules is compared every
// cycle, and each table entry also carries hand-computed write/stall expectations.
module tb_write_back;
    localparam int unsigned TO      = 16;
    localparam logic [31:0] TO_DATA = 32'hDEADBEEF;
    localparam logic [31:0] NOP     = 32'h83FF_F800;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] y;
        logic        ld;
        int          delay;
        logic [31:0] rdata;
        logic        lit;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        int          exp_stalls;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    write_back_if wb_if();

    write_back #(.LD_TIMEOUT(TO), .TIMEOUT_DATA(TO_DATA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] lo);
        return {op, rc, ra, lo};
    endfunction

    function automatic vec_t mkv(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] y,
                                 input logic ld, input int delay, input logic [31:0] rdata,
                                 input logic exp_we, input logic [4:0] exp_wa,
                                 input logic [31:0] exp_wd, input int exp_stalls);
        vec_t v;
        v.pc = pc; v.ir = ir; v.y = y; v.ld = ld; v.delay = delay; v.rdata = rdata;
        v.lit = 1'b1; v.exp_we = exp_we; v.exp_wa = exp_wa; v.exp_wd = exp_wd;
        v.exp_stalls = exp_stalls;
        return v;
    endfunction

    // 0 none, 1 load, 2 pc-link, 3 alu
    function automatic int kind(input logic [5:0] op);
        if (op == 6'h18 || op == 6'h1F) return 1;
        if (op == 6'h1B || op == 6'h1C || op == 6'h1D) return 2;
        if (op >= 6'h20) return 3;
        return 0;
    endfunction

    task automatic drive(input vec_t v);
        wb_if.pc           = v.pc;
        wb_if.ir           = v.ir;
        wb_if.y            = v.y;
        wb_if.op_ld_or_ldr = v.ld;
    endtask

    initial begin
        vec_t bubble, cur, nxt;
        int idx, waited, dut_stalls, cyc;
        logic sticky, rv, e_stall, e_we, e_to;
        logic [31:0] e_wd;

        bubble = mkv(32'h0, NOP, 32'h0, 1'b0, -1, 32'h0, 1'b0, 5'd31, 32'h0, 0);
        bubble.lit = 1'b0;

        vecs.push_back(mkv(32'h100, mk(6'h30, 5'd2,  5'd1, 16'd5), 32'd5, 1'b0, -1, 32'h0, 1'b1, 5'd2, 32'd5, 0));
        vecs.push_back(mkv(32'h104, mk(6'h1C, 5'd28, 5'd1, 16'd0), 32'h77, 1'b0, -1, 32'h0, 1'b1, 5'd28, 32'h104, 0));
        vecs.push_back(mkv(32'h108, mk(6'h19, 5'd5,  5'd1, 16'd0), 32'h88, 1'b0, -1, 32'h0, 1'b0, 5'd5, 32'h0, 0));
        vecs.push_back(mkv(32'h10C, mk(6'h20, 5'd31, 5'd1, 16'd0), 32'd9, 1'b0, -1, 32'h0, 1'b0, 5'd31, 32'h0, 0));
        vecs.push_back(mkv(32'h110, mk(6'h18, 5'd3,  5'd1, 16'd0), 32'h40, 1'b1, 3, 32'hCAFE, 1'b1, 5'd3, 32'hCAFE, 3));
        vecs.push_back(mkv(32'h114, mk(6'h20, 5'd10, 5'd1, 16'd0), 32'h1234, 1'b0, -1, 32'h0, 1'b1, 5'd10, 32'h1234, 0));
        vecs.push_back(mkv(32'h118, mk(6'h18, 5'd4,  5'd1, 16'd0), 32'h44, 1'b1, -1, 32'h0, 1'b1, 5'd4, 32'hDEADBEEF, 16));
        vecs.push_back(mkv(32'h11C, mk(6'h18, 5'd5,  5'd1, 16'd0), 32'h48, 1'b1, 0, 32'h1111, 1'b1, 5'd5, 32'h1111, 0));
        vecs.push_back(mkv(32'h120, mk(6'h1F, 5'd6,  5'd1, 16'd0), 32'h4C, 1'b1, 0, 32'h2222, 1'b1, 5'd6, 32'h2222, 0));
        vecs.push_back(mkv(32'h200, mk(6'h1B, 5'd7,  5'd1, 16'd0), 32'h99, 1'b0, -1, 32'h0, 1'b1, 5'd7, 32'h200, 0));
        vecs.push_back(mkv(32'h300, mk(6'h1D, 5'd30, 5'd1, 16'd0), 32'h98, 1'b0, -1, 32'h0, 1'b1, 5'd30, 32'h300, 0));
        vecs.push_back(mkv(32'h304, mk(6'h01, 5'd8,  5'd1, 16'd0), 32'h97, 1'b0, -1, 32'h0, 1'b0, 5'd8, 32'h0, 0));
        vecs.push_back(mkv(32'h308, mk(6'h18, 5'd11, 5'd1, 16'd0), 32'h96, 1'b0, 0, 32'hBAD0, 1'b0, 5'd11, 32'h0, 0));
        vecs.push_back(mkv(32'h30C, mk(6'h20, 5'd12, 5'd1, 16'd0), 32'h55, 1'b1, -1, 32'h0, 1'b1, 5'd12, 32'h55, 0));
        vecs.push_back(mkv(32'h310, mk(6'h20, 5'd13, 5'd1, 16'd0), 32'h66, 1'b0, 0, 32'hBAD1, 1'b1, 5'd13, 32'h66, 0));
        vecs.push_back(mkv(32'h314, mk(6'h18, 5'd31, 5'd1, 16'd0), 32'h50, 1'b1, 1, 32'h3333, 1'b0, 5'd31, 32'h0, 1));

        rst_n = 1'b0;
        drive(vecs[0]);
        wb_if.mem_rvalid = 1'b0;
        wb_if.mem_rdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", {31'b0, wb_if.stall_wb}, 32'd0);
        check("reset_we",    {31'b0, wb_if.rf_we}, 32'd0);
        check("reset_wa",    {27'b0, wb_if.rf_wa}, 32'd31);
        check("reset_wd",    wb_if.rf_wd, 32'd0);
        check("reset_ldto",  {31'b0, wb_if.ld_timeout}, 32'd0);
        rst_n = 1'b1;

        cur = bubble; idx = 0; waited = 0; dut_stalls = 0; sticky = 1'b0; cyc = 0;
        while (!(idx >= vecs.size() && !cur.lit)) begin
            if (cyc >= 500) begin
                check("cycle_budget", 32'(idx), 32'(vecs.size()));
                break;
            end
            cyc++;
            nxt = (idx < vecs.size()) ? vecs[idx] : bubble;
            drive(nxt);
            rv = (cur.delay >= 0) && (waited == cur.delay);
            wb_if.mem_rvalid = rv;
            wb_if.mem_rdata  = rv ? cur.rdata : 32'h5A5A_A5A5;
            #1;

            e_stall = 1'b0; e_we = 1'b0; e_to = 1'b0; e_wd = '0;
            if (cur.ld && kind(cur.ir[31:26]) == 1) begin
                if (rv) begin
                    e_we = 1'b1; e_wd = cur.rdata;
                end else if (TO != 0 && waited == int'(TO)) begin
                    e_we = 1'b1; e_wd = TO_DATA; e_to = 1'b1;
                end else begin
                    e_stall = 1'b1;
                end
            end else if (kind(cur.ir[31:26]) == 2) begin
                e_we = 1'b1; e_wd = cur.pc;
            end else if (kind(cur.ir[31:26]) == 3) begin
                e_we = 1'b1; e_wd = cur.y;
            end
            if (cur.ir[25:21] == 5'd31) e_we = 1'b0;

            check("stall_wb",   {31'b0, wb_if.stall_wb}, {31'b0, e_stall});
            check("rf_we",      {31'b0, wb_if.rf_we}, {31'b0, e_we});
            check("ld_timeout", {31'b0, wb_if.ld_timeout}, {31'b0, sticky});
            if (e_we) begin
                check("rf_wa", {27'b0, wb_if.rf_wa}, {27'b0, cur.ir[25:21]});
                check("rf_wd", wb_if.rf_wd, e_wd);
            end
            if (wb_if.stall_wb) dut_stalls++;

            if (cur.lit && !e_stall) begin
                check("lit_we", {31'b0, wb_if.rf_we}, {31'b0, cur.exp_we});
                if (cur.exp_we) begin
                    check("lit_wa", {27'b0, wb_if.rf_wa}, {27'b0, cur.exp_wa});
                    check("lit_wd", wb_if.rf_wd, cur.exp_wd);
                end
                check("lit_stalls", 32'(dut_stalls), 32'(cur.exp_stalls));
            end

            if (e_to) sticky = 1'b1;
            if (e_stall) begin
                waited++;
            end else begin
                cur = nxt;
                if (idx < vecs.size()) idx++;
                waited = 0;
                dut_stalls = 0;
            end
            @(posedge clk);
            @(negedge clk);
        end

        check("ldto_sticky", {31'b0, wb_if.ld_timeout}, 32'd1);

        // Load that never returns, then an asynchronous reset in the middle of the wait.
        drive(mkv(32'h400, mk(6'h18, 5'd9, 5'd1, 16'd0), 32'h0, 1'b1, -1, 32'h0, 1'b0, 5'd9, 32'h0, 0));
        wb_if.mem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midwait_stall0", {31'b0, wb_if.stall_wb}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("midwait_stall3", {31'b0, wb_if.stall_wb}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", {31'b0, wb_if.stall_wb}, 32'd0);
        check("rst_mid_we",    {31'b0, wb_if.rf_we}, 32'd0);
        check("rst_mid_wa",    {27'b0, wb_if.rf_wa}, 32'd31);
        check("rst_mid_wd",    wb_if.rf_wd, 32'd0);
        check("rst_mid_ldto",  {31'b0, wb_if.ld_timeout}, 32'd0);

        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
